// File: rtl/new_fsm.sv
// rtl/new_fsm.sv - SPGD iteration sequencer (+pert/settle/J+, -pert/settle/J-, U commit)
// Optional trigger synchronizer: define NEW_FSM_TRIG_SYNC_EN for a 2-flop TRIG_IN synchronizer.
module new_fsm #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       adc_clk,
    input  logic       adc_rstn,
    input  logic       start,
    input  logic       TRIG_IN,
    output logic       FSM_JP_WRT,
    output logic       FSM_JM_WRT,
    output logic       FSM_U_WRT,
    output logic [1:0] FSM_DAC_SEL,
    output logic [5:0] FSM_STATE
);

    localparam logic [5:0] ST_IDLE   = 6'd0;
    localparam logic [5:0] ST_ARMED  = 6'd1;
    localparam logic [5:0] ST_SET_P  = 6'd2;
    localparam logic [5:0] ST_WRT_P  = 6'd3;
    localparam logic [5:0] ST_SET_M  = 6'd4;
    localparam logic [5:0] ST_WRT_M  = 6'd5;
    localparam logic [5:0] ST_UPDATE = 6'd6;
    localparam logic [5:0] ST_DONE   = 6'd7;

    localparam logic [15:0] CNT_LAST = 16'(SETTLE_CYCLES - 1);

    logic [5:0]  state;
    logic [5:0]  next_state;
    logic [15:0] cnt;
    logic        trig_q;
    logic        trig_q_d;
    logic        rise;
    logic [1:0]  dac_next;
    logic        jp_next;
    logic        jm_next;
    logic        u_next;

`ifdef NEW_FSM_TRIG_SYNC_EN
    logic trig_meta;

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            trig_meta <= 1'b0;
            trig_q    <= 1'b0;
            trig_q_d  <= 1'b0;
        end else begin
            trig_meta <= TRIG_IN;
            trig_q    <= trig_meta;
            trig_q_d  <= trig_q;
        end
    end
`else
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            trig_q   <= 1'b0;
            trig_q_d <= 1'b0;
        end else begin
            trig_q   <= TRIG_IN;
            trig_q_d <= trig_q;
        end
    end
`endif

    assign rise = trig_q & ~trig_q_d;

    // Outputs are decoded from next_state and registered with the state, so they
    // change on the same edge as FSM_STATE.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            FSM_DAC_SEL <= 2'b00;
            FSM_JP_WRT  <= 1'b0;
            FSM_JM_WRT  <= 1'b0;
            FSM_U_WRT   <= 1'b0;
        end else begin
            state       <= next_state;
            FSM_DAC_SEL <= dac_next;
            FSM_JP_WRT  <= jp_next;
            FSM_JM_WRT  <= jm_next;
            FSM_U_WRT   <= u_next;
            if ((state == ST_SET_P || state == ST_SET_M) && next_state == state) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (!start) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   next_state = ST_ARMED;
                ST_ARMED:  if (rise) next_state = ST_SET_P;
                ST_SET_P:  if (cnt == CNT_LAST) next_state = ST_WRT_P;
                ST_WRT_P:  next_state = ST_SET_M;
                ST_SET_M:  if (cnt == CNT_LAST) next_state = ST_WRT_M;
                ST_WRT_M:  next_state = ST_UPDATE;
                ST_UPDATE: next_state = ST_DONE;
                ST_DONE:   next_state = ST_ARMED;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dac_next = 2'b00;
        jp_next  = 1'b0;
        jm_next  = 1'b0;
        u_next   = 1'b0;
        case (next_state)
            ST_SET_P:  dac_next = 2'b01;
            ST_WRT_P:  begin dac_next = 2'b01; jp_next = 1'b1; end
            ST_SET_M:  dac_next = 2'b10;
            ST_WRT_M:  begin dac_next = 2'b10; jm_next = 1'b1; end
            ST_UPDATE: u_next = 1'b1;
            default:   dac_next = 2'b00;
        endcase
    end

    assign FSM_STATE = state;

endmodule

// File: tb/tb_new_fsm.sv
// tb/tb_new_fsm.sv - randomized and directed checks of new_fsm against a phase-count model
module tb_new_fsm;
    localparam int S_A = 16;
    localparam int S_B = 1;
`ifdef NEW_FSM_TRIG_SYNC_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic trig = 1'b0;
    always #5 clk = ~clk;

    logic       a_jp, a_jm, a_u, b_jp, b_jm, b_u;
    logic [1:0] a_dac, b_dac;
    logic [5:0] a_st, b_st;

    new_fsm #(.SETTLE_CYCLES(S_A)) dut_a (
        .adc_clk(clk), .adc_rstn(rstn), .start(start), .TRIG_IN(trig),
        .FSM_JP_WRT(a_jp), .FSM_JM_WRT(a_jm), .FSM_U_WRT(a_u),
        .FSM_DAC_SEL(a_dac), .FSM_STATE(a_st)
    );

    new_fsm #(.SETTLE_CYCLES(S_B)) dut_b (
        .adc_clk(clk), .adc_rstn(rstn), .start(start), .TRIG_IN(trig),
        .FSM_JP_WRT(b_jp), .FSM_JM_WRT(b_jm), .FSM_U_WRT(b_u),
        .FSM_DAC_SEL(b_dac), .FSM_STATE(b_st)
    );

    int checks = 0;
    int errors = 0;
    // Model: phase -1 = idle, 0 = armed, k = k-th cycle since SET_P entry (1..2S+4).
    int ph_a = -1;
    int ph_b = -1;
    bit hist [0:2];
    int jp_n, jm_n, u_n;

    function automatic int exp_state(int ph, int s);
        if (ph < 0) return 0;
        if (ph == 0) return 1;
        if (ph <= s) return 2;
        if (ph == s + 1) return 3;
        if (ph <= 2 * s + 1) return 4;
        if (ph == 2 * s + 2) return 5;
        if (ph == 2 * s + 3) return 6;
        return 7;
    endfunction

    function automatic int next_ph(int ph, int s, bit st, bit rise);
        if (!st) return -1;
        if (ph < 0) return 0;
        if (ph == 0) return rise ? 1 : 0;
        if (ph < 2 * s + 4) return ph + 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int ph, input int s, input logic [5:0] st,
                             input logic [1:0] dac, input logic jp, input logic jm, input logic u);
        int e;
        int ed;
        e = exp_state(ph, s);
        ed = (e == 2 || e == 3) ? 1 : ((e == 4 || e == 5) ? 2 : 0);
        chk({nm, "_state"}, {2'b00, st}, 8'(e));
        chk({nm, "_dac"}, {6'd0, dac}, 8'(ed));
        chk({nm, "_jp"}, {7'd0, jp}, 8'(e == 3));
        chk({nm, "_jm"}, {7'd0, jm}, 8'(e == 5));
        chk({nm, "_u"}, {7'd0, u}, 8'(e == 6));
    endtask

    task automatic cycle(input bit s, input bit t);
        bit rise;
        start = s;
        trig = t;
        @(posedge clk);
        rise = hist[D] & ~hist[D + 1];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = t;
        ph_a = next_ph(ph_a, S_A, s, rise);
        ph_b = next_ph(ph_b, S_B, s, rise);
        @(negedge clk);
        check_dut("a", ph_a, S_A, a_st, a_dac, a_jp, a_jm, a_u);
        check_dut("b", ph_b, S_B, b_st, b_dac, b_jp, b_jm, b_u);
        jp_n += int'(a_jp);
        jm_n += int'(a_jm);
        u_n  += int'(a_u);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_dut("rst_a", -1, S_A, a_st, a_dac, a_jp, a_jm, a_u);
        check_dut("rst_b", -1, S_B, b_st, b_dac, b_jp, b_jm, b_u);
        ph_a = -1;
        ph_b = -1;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
        start = 1'b0;
        trig = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int first_setp;
        int jp_at, jm_at, u_at;
        bit t;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
        jp_n = 0; jm_n = 0; u_n = 0;

        // Power-on reset
        @(negedge clk);
        do_reset();

        // Arm without trigger for 20 cycles
        cycle(1'b1, 1'b0);
        jp_n = 0; jm_n = 0; u_n = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
        chk("armed_state", {2'b00, a_st}, 8'd1);
        chk("armed_no_strobe", 8'(jp_n + jm_n + u_n), 8'd0);

        // Full iteration: trigger high for 2 cycles
        first_setp = -1; jp_at = -1; jm_at = -1; u_at = -1;
        jp_n = 0; jm_n = 0; u_n = 0;
        for (int i = 0; i < 45; i++) begin
            cycle(1'b1, i < 2);
            if (a_st == 6'd2 && first_setp < 0) first_setp = i;
            if (a_jp) jp_at = i;
            if (a_jm) jm_at = i;
            if (a_u) u_at = i;
        end
        chk("trig_latency", 8'(first_setp), 8'(D + 1));
        chk("jp_offset", 8'(jp_at - first_setp + 1), 8'd17);
        chk("jm_offset", 8'(jm_at - first_setp + 1), 8'd34);
        chk("u_offset", 8'(u_at - first_setp + 1), 8'd35);
        chk("triplet_count", 8'(jp_n * 100 + jm_n * 10 + u_n), 8'd111);
        chk("end_armed", {2'b00, a_st}, 8'd1);

        // Abort during SET_M
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 40 && a_st != 6'd4; i++) cycle(1'b1, 1'b0);
        chk("reach_set_m", {2'b00, a_st}, 8'd4);
        jp_n = 0; jm_n = 0; u_n = 0;
        cycle(1'b0, 1'b0);
        chk("abort_idle", {2'b00, a_st}, 8'd0);
        chk("abort_dac", {6'd0, a_dac}, 8'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        chk("abort_no_strobe", 8'(jm_n + u_n), 8'd0);

        // Busy trigger: second pulse during SET_P is ignored
        cycle(1'b1, 1'b0);
        jp_n = 0; jm_n = 0; u_n = 0;
        for (int i = 0; i < 55; i++) cycle(1'b1, (i < 2) || (i >= 7 && i < 9));
        chk("busy_triplet", 8'(jp_n * 100 + jm_n * 10 + u_n), 8'd111);

        // Reset mid-sequence
        for (int i = 0; i < 12; i++) cycle(1'b1, i < 2);
        do_reset();

        // Randomized traffic with occasional aborts and resets
        t = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                t = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) t = ~t;
                cycle($urandom_range(0, 127) != 0, t);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
